// File: rtl/centroid_update.sv
// K-means centroid update: accumulates per-cluster coordinate sums/counts, then
// walks the clusters through an external combinational divider to emit centroids.
module centroid_update #(
   parameter int K  = 4,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pt_valid,
   input  logic [DW-1:0] pt_x,
   input  logic [DW-1:0] pt_y,
   input  logic [1:0]    pt_cid,
   input  logic          pt_last,
   output logic          pt_ready,
   output logic [31:0]   div_a,
   output logic [31:0]   div_b,
   input  logic [31:0]   div_q,
   output logic          cen_valid,
   output logic [1:0]    cen_id,
   output logic [DW-1:0] cen_x,
   output logic [DW-1:0] cen_y,
   output logic          cen_empty,
   output logic          busy,
   output logic          done,
   output logic          ovf
);

   typedef enum logic [1:0] {S_ACCUM, S_DIV_X, S_DIV_Y} state_t;

   state_t        state_q, state_d;
   logic [1:0]    k_q, k_d;
   logic [31:0]   sum_x_q [K], sum_x_d [K];
   logic [31:0]   sum_y_q [K], sum_y_d [K];
   logic [15:0]   cnt_q   [K], cnt_d   [K];
   logic [DW-1:0] qx_q, qx_d;
   logic          cen_valid_q, cen_valid_d;
   logic [1:0]    cen_id_q, cen_id_d;
   logic [DW-1:0] cen_x_q, cen_x_d;
   logic [DW-1:0] cen_y_q, cen_y_d;
   logic          cen_empty_q, cen_empty_d;
   logic          done_q, done_d;
   logic          ovf_q, ovf_d;
   logic          fresh_q, fresh_d;
   logic          accept;
   logic          cnt_zero;
   logic          div_q_unused;

   // Quotient cannot exceed 2^DW-1, so the upper bits carry no information.
   assign div_q_unused = |div_q[31:DW];

   assign busy      = (state_q != S_ACCUM);
   assign pt_ready  = !busy;
   assign accept    = pt_valid && pt_ready;
   assign cnt_zero  = (cnt_q[k_q] == '0);

   assign cen_valid = cen_valid_q;
   assign cen_id    = cen_id_q;
   assign cen_x     = cen_x_q;
   assign cen_y     = cen_y_q;
   assign cen_empty = cen_empty_q;
   assign done      = done_q;
   assign ovf       = ovf_q;

   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      sum_x_d     = sum_x_q;
      sum_y_d     = sum_y_q;
      cnt_d       = cnt_q;
      qx_d        = qx_q;
      cen_valid_d = 1'b0;
      cen_id_d    = cen_id_q;
      cen_x_d     = cen_x_q;
      cen_y_d     = cen_y_q;
      cen_empty_d = cen_empty_q;
      done_d      = 1'b0;
      ovf_d       = ovf_q;
      fresh_d     = fresh_q;
      div_a       = '0;
      div_b       = 32'd1;

      case (state_q)
         S_ACCUM: begin
            if (accept) begin
               // ovf survives until the first point of the following epoch so
               // that it can still be read alongside done.
               fresh_d = 1'b0;
               if (fresh_q) ovf_d = 1'b0;
               if (cnt_q[pt_cid] == '1) begin
                  ovf_d = 1'b1;
               end else begin
                  sum_x_d[pt_cid] = sum_x_q[pt_cid] + 32'(pt_x);
                  sum_y_d[pt_cid] = sum_y_q[pt_cid] + 32'(pt_y);
                  cnt_d[pt_cid]   = cnt_q[pt_cid] + 16'd1;
               end
               if (pt_last) begin
                  state_d = S_DIV_X;
                  k_d     = '0;
               end
            end
         end
         S_DIV_X: begin
            div_a   = sum_x_q[k_q];
            div_b   = cnt_zero ? 32'd1 : 32'(cnt_q[k_q]);
            qx_d    = div_q[DW-1:0];
            state_d = S_DIV_Y;
         end
         S_DIV_Y: begin
            div_a       = sum_y_q[k_q];
            div_b       = cnt_zero ? 32'd1 : 32'(cnt_q[k_q]);
            cen_valid_d = 1'b1;
            cen_id_d    = k_q;
            cen_empty_d = cnt_zero;
            cen_x_d     = cnt_zero ? '0 : qx_q;
            cen_y_d     = cnt_zero ? '0 : div_q[DW-1:0];
            if (k_q == 2'(K - 1)) begin
               state_d = S_ACCUM;
               done_d  = 1'b1;
               fresh_d = 1'b1;
               for (int unsigned i = 0; i < K; i++) begin
                  sum_x_d[i] = '0;
                  sum_y_d[i] = '0;
                  cnt_d[i]   = '0;
               end
            end else begin
               k_d     = k_q + 2'd1;
               state_d = S_DIV_X;
            end
         end
         default: state_d = S_ACCUM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_ACCUM;
         k_q         <= '0;
         sum_x_q     <= '{default: '0};
         sum_y_q     <= '{default: '0};
         cnt_q       <= '{default: '0};
         qx_q        <= '0;
         cen_valid_q <= 1'b0;
         cen_id_q    <= '0;
         cen_x_q     <= '0;
         cen_y_q     <= '0;
         cen_empty_q <= 1'b0;
         done_q      <= 1'b0;
         ovf_q       <= 1'b0;
         fresh_q     <= 1'b1;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         sum_x_q     <= sum_x_d;
         sum_y_q     <= sum_y_d;
         cnt_q       <= cnt_d;
         qx_q        <= qx_d;
         cen_valid_q <= cen_valid_d;
         cen_id_q    <= cen_id_d;
         cen_x_q     <= cen_x_d;
         cen_y_q     <= cen_y_d;
         cen_empty_q <= cen_empty_d;
         done_q      <= done_d;
         ovf_q       <= ovf_d;
         fresh_q     <= fresh_d;
      end
   end

endmodule

// File: tb/tb_centroid_update.sv
// Randomized and directed bench for centroid_update; expected centroids come
// from a per-cluster sum/count model and integer division.
module tb_centroid_update;

   logic        clk = 1'b0;
   logic        rst;
   logic        pt_valid;
   logic [15:0] pt_x;
   logic [15:0] pt_y;
   logic [1:0]  pt_cid;
   logic        pt_last;
   logic        pt_ready;
   logic [31:0] div_a;
   logic [31:0] div_b;
   logic [31:0] div_q;
   logic        cen_valid;
   logic [1:0]  cen_id;
   logic [15:0] cen_x;
   logic [15:0] cen_y;
   logic        cen_empty;
   logic        busy;
   logic        done;
   logic        ovf;

   int checks = 0;
   int errors = 0;

   longint m_sx [4];
   longint m_sy [4];
   longint m_cnt[4];

   logic        cap_cv [1:10];
   logic        cap_dn [1:10];
   logic        cap_bz [1:10];
   logic        cap_rd [1:10];
   logic        cap_em [1:10];
   logic        cap_ov [1:10];
   logic [1:0]  cap_id [1:10];
   logic [15:0] cap_x  [1:10];
   logic [15:0] cap_y  [1:10];
   logic [31:0] cap_da [1:10];
   logic [31:0] cap_db [1:10];

   centroid_update #(.K(4), .DW(16)) dut (
      .clk(clk), .rst(rst),
      .pt_valid(pt_valid), .pt_x(pt_x), .pt_y(pt_y), .pt_cid(pt_cid), .pt_last(pt_last),
      .pt_ready(pt_ready),
      .div_a(div_a), .div_b(div_b), .div_q(div_q),
      .cen_valid(cen_valid), .cen_id(cen_id), .cen_x(cen_x), .cen_y(cen_y),
      .cen_empty(cen_empty), .busy(busy), .done(done), .ovf(ovf)
   );

   always #5 clk = ~clk;

   // External combinational divider.
   assign div_q = (div_b == 32'd0) ? 32'd0 : div_a / div_b;

   always @(negedge clk) begin
      if (rst === 1'b0) begin
         checks++;
         if (div_b === 32'd0 || pt_ready !== !busy) begin
            errors++;
            $display("FAIL div_b_ready got div_b=%0d ready=%0d busy=%0d", div_b, pt_ready, busy);
         end
      end
   end

   function automatic void model_clear();
      for (int i = 0; i < 4; i++) begin
         m_sx[i] = 0; m_sy[i] = 0; m_cnt[i] = 0;
      end
   endfunction

   function automatic void exp_cen(input int k, output longint ex, output longint ey, output bit ee);
      ee = (m_cnt[k] == 0);
      ex = ee ? 0 : m_sx[k] / m_cnt[k];
      ey = ee ? 0 : m_sy[k] / m_cnt[k];
   endfunction

   // Presents one point for one cycle (DUT assumed idle) and updates the model.
   task automatic send_point(input int x, input int y, input int cid, input bit last);
      pt_valid = 1'b1; pt_x = 16'(x); pt_y = 16'(y); pt_cid = 2'(cid); pt_last = last;
      if (m_cnt[cid] < 65535) begin
         m_sx[cid] += x; m_sy[cid] += y; m_cnt[cid] += 1;
      end
      @(posedge clk); #1;
      pt_valid = 1'b0; pt_last = 1'b0;
   endtask

   // Records cycles T+1..T+10 after the last point; optionally offers junk points while busy.
   task automatic capture(input bit junk);
      for (int i = 1; i <= 10; i++) begin
         if (junk && i <= 8) begin
            pt_valid = 1'($urandom); pt_x = 16'($urandom); pt_y = 16'($urandom);
            pt_cid = 2'($urandom); pt_last = 1'($urandom);
         end else begin
            pt_valid = 1'b0; pt_last = 1'b0;
         end
         @(negedge clk);
         cap_cv[i] = cen_valid; cap_dn[i] = done; cap_bz[i] = busy; cap_rd[i] = pt_ready;
         cap_em[i] = cen_empty; cap_ov[i] = ovf; cap_id[i] = cen_id;
         cap_x[i] = cen_x; cap_y[i] = cen_y; cap_da[i] = div_a; cap_db[i] = div_b;
         @(posedge clk); #1;
      end
      pt_valid = 1'b0; pt_last = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; pt_valid = 1'b0; pt_x = '0; pt_y = '0; pt_cid = '0; pt_last = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checks++;
      if (pt_ready !== 1'b1 || busy !== 1'b0 || cen_valid !== 1'b0 || done !== 1'b0 || ovf !== 1'b0 ||
          cen_x !== 16'd0 || cen_y !== 16'd0 || cen_id !== 2'd0 || cen_empty !== 1'b0 ||
          div_a !== 32'd0 || div_b !== 32'd1) begin
         errors++;
         $display("FAIL reset_state got ready=%0d busy=%0d cv=%0d done=%0d ovf=%0d x=%0d y=%0d id=%0d e=%0d da=%0d db=%0d exp ready=1 db=1 rest 0",
                  pt_ready, busy, cen_valid, done, ovf, cen_x, cen_y, cen_id, cen_empty, div_a, div_b);
      end
      @(posedge clk); #1;
      model_clear();
   endtask

   task automatic test_directed();
      longint ex, ey; bit ee;
      send_point(10, 20, 0, 0);
      send_point(20, 40, 0, 0);
      send_point(31, 61, 0, 0);
      send_point(4637, 123, 1, 1);
      capture(0);
      for (int k = 0; k < 4; k++) begin
         int c = 3 + 2 * k;
         exp_cen(k, ex, ey, ee);
         checks++;
         if (cap_cv[c] !== 1'b1 || cap_id[c] !== 2'(k) || cap_x[c] !== 16'(ex) || cap_y[c] !== 16'(ey) || cap_em[c] !== ee) begin
            errors++;
            $display("FAIL directed_cen k=%0d got v=%0d id=%0d (%0d,%0d) e=%0d exp (%0d,%0d) e=%0d",
                     k, cap_cv[c], cap_id[c], cap_x[c], cap_y[c], cap_em[c], ex, ey, ee);
         end
      end
      for (int i = 1; i <= 10; i++) begin
         checks++;
         if (cap_cv[i] !== (i >= 3 && i <= 9 && i % 2 == 1) || cap_dn[i] !== (i == 9) ||
             cap_bz[i] !== (i <= 8) || cap_rd[i] !== (i > 8)) begin
            errors++;
            $display("FAIL directed_shape cyc=T+%0d got cv=%0d done=%0d busy=%0d rdy=%0d", i, cap_cv[i], cap_dn[i], cap_bz[i], cap_rd[i]);
         end
      end
      model_clear();
   endtask

   task automatic test_max_coord();
      send_point(65535, 65535, 3, 0);
      send_point(65535, 65535, 3, 1);
      capture(0);
      checks++;
      if (cap_da[7] !== 32'd131070 || cap_db[7] !== 32'd2) begin
         errors++;
         $display("FAIL max_div_inputs got a=%0d b=%0d exp a=131070 b=2", cap_da[7], cap_db[7]);
      end
      checks++;
      if (cap_cv[9] !== 1'b1 || cap_id[9] !== 2'd3 || cap_x[9] !== 16'd65535 || cap_y[9] !== 16'd65535 ||
          cap_em[9] !== 1'b0 || cap_dn[9] !== 1'b1) begin
         errors++;
         $display("FAIL max_cen got v=%0d id=%0d (%0d,%0d) e=%0d done=%0d exp id=3 (65535,65535) e=0 done=1",
                  cap_cv[9], cap_id[9], cap_x[9], cap_y[9], cap_em[9], cap_dn[9]);
      end
      checks++;
      if (cap_em[3] !== 1'b1 || cap_x[3] !== 16'd0 || cap_db[1] !== 32'd1) begin
         errors++;
         $display("FAIL max_empty0 got e=%0d x=%0d db=%0d exp e=1 x=0 db=1", cap_em[3], cap_x[3], cap_db[1]);
      end
      model_clear();
   endtask

   task automatic test_ignore_busy();
      longint ex, ey; bit ee;
      send_point(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)), 2, 1);
      capture(1);
      model_clear();
      send_point(5, 6, 1, 0);
      send_point(9, 8, 1, 1);
      capture(0);
      for (int k = 0; k < 4; k++) begin
         int c = 3 + 2 * k;
         exp_cen(k, ex, ey, ee);
         checks++;
         if (cap_cv[c] !== 1'b1 || cap_id[c] !== 2'(k) || cap_x[c] !== 16'(ex) || cap_y[c] !== 16'(ey) || cap_em[c] !== ee) begin
            errors++;
            $display("FAIL busy_ignore_cen k=%0d got (%0d,%0d) e=%0d exp (%0d,%0d) e=%0d",
                     k, cap_x[c], cap_y[c], cap_em[c], ex, ey, ee);
         end
      end
      model_clear();
   endtask

   task automatic test_reset_mid();
      longint ex, ey; bit ee;
      send_point(100, 200, 1, 1);
      for (int i = 1; i <= 4; i++) begin
         if (i == 4) rst = 1'b1;
         @(posedge clk); #1;
      end
      rst = 1'b0;
      model_clear();
      for (int i = 5; i <= 12; i++) begin
         @(negedge clk);
         checks++;
         if (cen_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || pt_ready !== 1'b1 ||
             cen_x !== 16'd0 || cen_empty !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid cyc=T+%0d got cv=%0d done=%0d busy=%0d rdy=%0d x=%0d e=%0d exp 0 0 0 1 0 0",
                     i, cen_valid, done, busy, pt_ready, cen_x, cen_empty);
         end
         @(posedge clk); #1;
      end
      send_point(7, 9, 0, 1);
      capture(0);
      for (int k = 0; k < 4; k++) begin
         int c = 3 + 2 * k;
         exp_cen(k, ex, ey, ee);
         checks++;
         if (cap_cv[c] !== 1'b1 || cap_id[c] !== 2'(k) || cap_x[c] !== 16'(ex) || cap_y[c] !== 16'(ey) || cap_em[c] !== ee) begin
            errors++;
            $display("FAIL reset_mid_cen k=%0d got (%0d,%0d) e=%0d exp (%0d,%0d) e=%0d",
                     k, cap_x[c], cap_y[c], cap_em[c], ex, ey, ee);
         end
      end
      model_clear();
   endtask

   task automatic test_random();
      longint ex, ey; bit ee;
      for (int ep = 0; ep < 6; ep++) begin
         int n = int'($urandom_range(1, 30));
         for (int p = 0; p < n; p++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            send_point(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
                       int'($urandom_range(0, 3)), p == n - 1);
         end
         capture(1);
         for (int k = 0; k < 4; k++) begin
            int c = 3 + 2 * k;
            exp_cen(k, ex, ey, ee);
            checks++;
            if (cap_cv[c] !== 1'b1 || cap_id[c] !== 2'(k) || cap_x[c] !== 16'(ex) || cap_y[c] !== 16'(ey) ||
                cap_em[c] !== ee || cap_x[c+1] !== 16'(ex) || cap_cv[c+1] !== 1'b0) begin
               errors++;
               $display("FAIL random_cen ep=%0d k=%0d got (%0d,%0d) e=%0d hold=%0d exp (%0d,%0d) e=%0d",
                        ep, k, cap_x[c], cap_y[c], cap_em[c], cap_x[c+1], ex, ey, ee);
            end
         end
         checks++;
         if (cap_dn[9] !== 1'b1 || cap_dn[10] !== 1'b0 || cap_bz[1] !== 1'b1 || cap_bz[9] !== 1'b0 || cap_ov[9] !== 1'b0) begin
            errors++;
            $display("FAIL random_shape ep=%0d got done9=%0d done10=%0d busy1=%0d busy9=%0d ovf=%0d",
                     ep, cap_dn[9], cap_dn[10], cap_bz[1], cap_bz[9], cap_ov[9]);
         end
         model_clear();
      end
   endtask

   task automatic test_overflow();
      longint ex, ey; bit ee;
      for (int i = 0; i < 65536; i++) send_point(1, 1, 0, 0);
      @(negedge clk);
      checks++;
      if (ovf !== 1'b1) begin
         errors++;
         $display("FAIL ovf_set got %0d exp 1", ovf);
      end
      @(posedge clk); #1;
      send_point(1, 1, 0, 1);
      capture(0);
      exp_cen(0, ex, ey, ee);
      checks++;
      if (cap_x[3] !== 16'(ex) || cap_y[3] !== 16'(ey) || cap_em[3] !== ee || cap_cv[3] !== 1'b1) begin
         errors++;
         $display("FAIL ovf_cen got (%0d,%0d) e=%0d exp (%0d,%0d) e=%0d", cap_x[3], cap_y[3], cap_em[3], ex, ey, ee);
      end
      checks++;
      if (cap_ov[9] !== 1'b1 || cap_dn[9] !== 1'b1) begin
         errors++;
         $display("FAIL ovf_hold_at_done got ovf=%0d done=%0d exp 1 1", cap_ov[9], cap_dn[9]);
      end
      model_clear();
      send_point(3, 4, 2, 0);
      @(negedge clk);
      checks++;
      if (ovf !== 1'b0) begin
         errors++;
         $display("FAIL ovf_clear got %0d exp 0", ovf);
      end
      @(posedge clk); #1;
      send_point(5, 6, 2, 1);
      capture(0);
      exp_cen(2, ex, ey, ee);
      checks++;
      if (cap_x[7] !== 16'(ex) || cap_y[7] !== 16'(ey) || cap_em[7] !== ee) begin
         errors++;
         $display("FAIL ovf_next_epoch got (%0d,%0d) e=%0d exp (%0d,%0d) e=%0d", cap_x[7], cap_y[7], cap_em[7], ex, ey, ee);
      end
      model_clear();
   endtask

   initial begin
      model_clear();
      test_reset();
      test_directed();
      test_max_coord();
      test_ignore_busy();
      test_reset_mid();
      test_random();
      test_overflow();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/centroid_update.md
CENTROID_UPDATE -- requirements
Module: centroid_update

Interface
REQ-001 Parameter K, default 4: number of clusters, fixed at 4 (2-bit cluster id).
REQ-002 Parameter DW, default 16: coordinate width (unsigned).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 pt_valid  input  1  point present on pt_x/pt_y/pt_cid this cycle.
REQ-006 pt_x  input  16  point x coordinate, unsigned.
REQ-007 pt_y  input  16  point y coordinate, unsigned.
REQ-008 pt_cid  input  2  cluster index assigned to the point.
REQ-009 pt_last  input  1  with pt_valid: final point of the epoch.
REQ-010 pt_ready  output  1  point accepted when pt_valid and pt_ready are both high; equals !busy.
REQ-011 div_a  output  32  dividend to the external combinational divider (div_rill .a).
REQ-012 div_b  output  32  divisor to the divider (div_rill .b).
REQ-013 div_q  input  32  quotient from the divider (div_rill .yshang), valid in the same cycle.
REQ-014 cen_valid  output  1  one-cycle pulse; cen_id/cen_x/cen_y/cen_empty valid.
REQ-015 cen_id  output  2  cluster index of the emitted centroid.
REQ-016 cen_x  output  16  new centroid x.
REQ-017 cen_y  output  16  new centroid y.
REQ-018 cen_empty  output  1  cluster received zero points this epoch.
REQ-019 busy  output  1  high while the divide sequence runs.
REQ-020 done  output  1  one-cycle pulse with the final cluster's cen_valid.
REQ-021 ovf  output  1  sticky flag; a point was dropped on count saturation; cleared by rst or at the start of the next epoch.

Function
REQ-022 Per cluster k, the block shall hold sum_x[k] (32b), sum_y[k] (32b) and cnt[k] (16b).
REQ-023 States shall be ACCUM, DIV_X, DIV_Y, with counter k over 0..3.
REQ-024 ACCUM: on an accepted point, sum_x[cid] += pt_x, sum_y[cid] += pt_y and cnt[cid] += 1, all in the same edge.
REQ-025 A point arriving with cnt[cid] == 65535 shall be dropped (no sum or count update) and shall set ovf.
REQ-026 An accepted point with pt_last shall be accumulated and then move ACCUM->DIV_X with k=0 at the same edge.
REQ-027 DIV_X: div_a = sum_x[k], div_b = cnt[k]; div_q shall be registered into internal qx; next state DIV_Y.
REQ-028 DIV_Y: div_a = sum_y[k], div_b = cnt[k]; at the edge: cen_valid<=1, cen_id<=k, cen_x<=qx[15:0], cen_y<=div_q[15:0], cen_empty<=(cnt[k]==0).
REQ-029 After DIV_Y: if k<3, then k+1 and next state DIV_X; if k==3, next state ACCUM, done<=1, and all sums and counts cleared to 0.
REQ-030 When cnt[k]==0: div_b shall be 1 (never 0), cen_x=cen_y=0 and cen_empty=1.
REQ-031 Quotient is at most 65535 by construction (sum <= cnt*65535); only the low 16 bits are used.
REQ-032 Outside DIV_X/DIV_Y, div_a=0 and div_b=1.
REQ-033 busy shall be high exactly while the state is DIV_X or DIV_Y; pt_ready=!busy; pt_valid while busy shall be ignored.
REQ-034 Timing: pt_last accepted in cycle T gives cen_valid in cycles T+3, T+5, T+7 and T+9 (k=0..3) and done in T+9; busy is high T+1..T+8.
REQ-035 cen_valid and done shall be high for one cycle only; cen_x/cen_y/cen_id/cen_empty hold their values until the next cen_valid.
REQ-036 An epoch with all cnt==0 still runs the full sequence; all four outputs have cen_empty=1.

Reset
REQ-037 rst, including mid-sequence, shall force state ACCUM, k=0, and clear all sums, counts, qx, cen_* outputs, done, busy and ovf to 0.
REQ-038 After rst deasserts, pt_ready=1 in the first cycle.

Verification
REQ-039 Points c0:(10,20),(20,40),(31,61); c1:(4637,123) last -> cen c0=(20,40), c1=(4637,123); c2 and c3 empty=1 with (0,0); done at T+9.
REQ-040 c3:(65535,65535) twice with last -> cen c3=(65535,65535), empty=0; div_a=131070 and div_b=2 observed in the DIV_X cycle.
REQ-041 Single pt_last point to c2, then pt_valid held high for cycles T+1..T+8 -> those points are not accumulated; the next epoch's sums start from 0.
REQ-042 rst asserted at T+4 mid-sequence -> no further cen_valid or done; busy=0 at T+5; a new epoch with point c0:(7,9) last -> c0=(7,9).
REQ-043 65536 points of (1,1) to c0, then last -> ovf=1, cen c0=(1,1) from cnt=65535; ovf cleared after the next epoch starts.
REQ-044 Check the pulse shapes in all scenarios: cen_valid is exactly four one-cycle pulses per epoch, two cycles apart, and div_b is never 0.
